// File: rtl/uart_banner_echo_top.sv
// UART 8N1 top: sends "ARM\r\n" once after reset, then echoes every good RX byte and latches it on the LEDs.
// Echo starts two cycles after the RX stop sample; a one-entry buffer keeps only the newest byte while TX is busy.
`timescale 1ns/1ps
module uart_banner_echo_top #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       CLK_I,
  input  logic       UART_RTS_N_I,
  input  logic       UART_RX_I,
  output logic       UART_TX_O,
  output logic [7:0] LED_IO
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic clk;
  logic rst;
  assign clk = CLK_I;
  assign rst = UART_RTS_N_I;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_FRAME_ERR} rx_state_t;
  typedef enum logic {BN_SEND, BN_DONE} bn_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_line;
  logic             tx_idle;
  logic             tx_start;
  logic [7:0]       tx_byte;

  rx_state_t        rx_state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_vld;
  logic [7:0]       rx_dat;

  bn_state_t        bn_state;
  logic [2:0]       bn_idx;
  logic [7:0]       bn_char;

  logic             buf_full;
  logic [7:0]       buf_dat;
  logic             buf_drain;
  logic [7:0]       led;

  // Banner has priority on TX; the echo buffer only drains once the banner is finished.
  assign tx_idle   = (tx_state == TX_IDLE);
  assign buf_drain = tx_idle && (bn_state == BN_DONE) && buf_full;
  assign tx_start  = tx_idle && ((bn_state == BN_SEND) || buf_full);
  assign tx_byte   = (bn_state == BN_SEND) ? bn_char : buf_dat;

  always_comb begin
    bn_char = 8'h0A;
    case (bn_idx)
      3'd0:    bn_char = 8'h41;
      3'd1:    bn_char = 8'h52;
      3'd2:    bn_char = 8'h4D;
      3'd3:    bn_char = 8'h0D;
      default: bn_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shift <= tx_byte;
            tx_cnt   <= '0;
            tx_line  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bn_state <= BN_SEND;
      bn_idx   <= '0;
    end else if (bn_state == BN_SEND && tx_idle) begin
      if (bn_idx == 3'd4) begin
        bn_state <= BN_DONE;
      end else begin
        bn_idx <= bn_idx + 3'd1;
      end
    end
  end

  // Start is qualified by a falling edge of the synchronized line, then confirmed at mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_vld   <= 1'b0;
      rx_dat   <= '0;
    end else begin
      rx_s1   <= UART_RX_I;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_vld  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_vld   <= 1'b1;
              rx_dat   <= rx_shift;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_FRAME_ERR;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_FRAME_ERR: begin
          if (rx_s2) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A new byte wins over a same-cycle drain, so the buffer stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_dat  <= '0;
      led      <= '0;
    end else begin
      if (rx_vld) begin
        buf_dat  <= rx_dat;
        buf_full <= 1'b1;
        led      <= rx_dat;
      end else if (buf_drain) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign UART_TX_O = tx_line;
  assign LED_IO    = led;

endmodule

// File: tb/tb_uart_banner_echo_top.sv
// Bench for uart_banner_echo_top: banner, table-driven RX vectors, random bursts against a byte-level model, reset corners.
`timescale 1ns/1ps
module tb_uart_banner_echo_top;

  localparam int CPB = 12000000 / 115200;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [7:0] led;

  uart_banner_echo_top dut (
    .CLK_I       (clk),
    .UART_RTS_N_I(rst),
    .UART_RX_I   (rx),
    .UART_TX_O   (tx),
    .LED_IO      (led)
  );

  always #42 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  b;
    logic        ok;
    logic [31:0] t0;
  } frame_t;
  frame_t tx_q[$];

  // Independent frame decoder on the TX pin: samples each bit at its middle.
  logic        mon_abort = 1'b1;
  logic        mon_busy  = 1'b0;
  int          mon_cnt;
  logic [31:0] mon_t0;
  logic [9:0]  mon_bits;
  always @(negedge clk) begin : monitor
    int     k;
    frame_t fr;
    if (mon_abort) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        mon_t0   = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        k = mon_cnt / CPB;
        mon_bits[k] = tx;
        if (k == 9) begin
          fr.b  = mon_bits[8:1];
          fr.ok = (mon_bits[0] === 1'b0) && (mon_bits[9] === 1'b1);
          fr.t0 = mon_t0;
          tx_q.push_back(fr);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int i = 0;
    while (tx_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("%s_arrive", name), tx_q.size() >= n, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned stop_start);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    stop_start = cyc;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  int unsigned rel_cyc;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mon_abort = 1'b1;
    repeat (3) @(negedge clk);
    tx_q.delete();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    mon_abort = 1'b0;
    rel_cyc = cyc + 1;
  endtask

  logic [7:0] banner [5];

  task automatic check_banner(input string tag);
    if (tx_q.size() >= 5) begin
      check_range($sformatf("%s_start_lat", tag), int'(tx_q[0].t0 - rel_cyc), 0, 2);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("%s_byte%0d", tag, i), tx_q[i].b, banner[i]);
        check($sformatf("%s_frame%0d", tag, i), tx_q[i].ok, 1'b1);
        if (i > 0)
          check_range($sformatf("%s_gap%0d", tag, i), int'(tx_q[i].t0 - tx_q[i-1].t0), 10*CPB, 10*CPB + 2);
      end
      repeat (5) void'(tx_q.pop_front());
    end
  endtask

  typedef struct packed {
    logic [7:0] glitch_len;
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_led;
    logic       exp_echo;
  } vec_t;
  vec_t vecs [8];

  int unsigned ss;
  frame_t      f;
  logic [7:0]  b;
  logic        good;
  int          n;
  int          led_nz;
  int          w;
  logic [7:0]  led_model;
  logic [7:0]  exp_q[$];

  initial begin
    banner[0] = 8'h41; banner[1] = 8'h52; banner[2] = 8'h4D; banner[3] = 8'h0D; banner[4] = 8'h0A;
    vecs[0] = '{8'd0,  8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[1] = '{8'd0,  8'hC3, 1'b0, 8'h5A, 1'b0};
    vecs[2] = '{8'd0,  8'h11, 1'b1, 8'h11, 1'b1};
    vecs[3] = '{8'd20, 8'h00, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{8'd0,  8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'd0,  8'h00, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'd40, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'd0,  8'hA5, 1'b0, 8'h00, 1'b0};

    // Power-up: reset state, then banner with RX idle.
    rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_led", led, 8'h00);
    release_reset();
    led_nz = 0;
    for (int i = 0; i < 6000 && tx_q.size() < 5; i++) begin
      @(negedge clk);
      if (led !== 8'h00) led_nz++;
    end
    check("banner_arrive", tx_q.size() >= 5, 1'b1);
    check_banner("banner");
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (led !== 8'h00) led_nz++;
    end
    check("banner_no_resend", tx_q.size(), 0);
    check("banner_tx_idle", tx, 1'b1);
    check("banner_led_zero", led_nz, 0);

    // Table-driven RX vectors after the banner.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].glitch_len != 0) begin
        @(negedge clk);
        rx = 1'b0;
        repeat (int'(vecs[v].glitch_len)) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
        check($sformatf("vec%0d_no_echo", v), tx_q.size(), 0);
      end else begin
        send_frame(vecs[v].data, vecs[v].stop, ss);
        if (!vecs[v].stop) repeat (CPB) @(negedge clk);
        check($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
        if (vecs[v].exp_echo) begin
          wait_frames(1, 1500, $sformatf("vec%0d_echo", v));
          if (tx_q.size() > 0) begin
            f = tx_q.pop_front();
            check($sformatf("vec%0d_echo_byte", v), f.b, vecs[v].data);
            check($sformatf("vec%0d_echo_frame", v), f.ok, 1'b1);
            check_range($sformatf("vec%0d_echo_lat", v), int'(f.t0 - ss), CPB/2 + 2, CPB/2 + 6);
          end
        end else begin
          repeat (1300) @(negedge clk);
          check($sformatf("vec%0d_no_echo", v), tx_q.size(), 0);
        end
      end
    end

    // Random bursts: LEDs follow the last good byte, TX echoes good bytes in order.
    led_model = vecs[7].exp_led;
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      tx_q.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        good = ($urandom_range(0, 4) != 0);
        send_frame(b, good, ss);
        if (good) begin
          led_model = b;
          exp_q.push_back(b);
        end else begin
          repeat (CPB) @(negedge clk);
        end
      end
      wait_frames(exp_q.size(), 2500, $sformatf("rand%0d", r));
      repeat (1200) @(negedge clk);
      check($sformatf("rand%0d_led", r), led, led_model);
      check($sformatf("rand%0d_count", r), tx_q.size(), exp_q.size());
      while (tx_q.size() > 0 && exp_q.size() > 0) begin
        f = tx_q.pop_front();
        check($sformatf("rand%0d_echo", r), f.b, exp_q.pop_front());
      end
    end

    // Two bytes during the banner: newest overwrites, sent right after LF.
    do_reset();
    check("rst2_led", led, 8'h00);
    release_reset();
    repeat (500) @(negedge clk);
    send_frame(8'h21, 1'b1, ss);
    check("ban_led21", led, 8'h21);
    send_frame(8'h33, 1'b1, ss);
    check("ban_led33", led, 8'h33);
    check("ban_still_busy", tx_q.size() < 5, 1'b1);
    wait_frames(6, 6000, "ban_echo");
    repeat (1200) @(negedge clk);
    check("ban_total", tx_q.size(), 6);
    if (tx_q.size() >= 6) begin
      check("ban_echo33", tx_q[5].b, 8'h33);
      check_range("ban_gap_33", int'(tx_q[5].t0 - tx_q[4].t0), 10*CPB, 10*CPB + 2);
    end
    check_banner("ban");

    // Reset in the middle of 'R' while the line is low.
    do_reset();
    check("rst3_led", led, 8'h00);
    check("rst3_tx", tx, 1'b1);
    release_reset();
    wait_frames(1, 1200, "midr_a");
    w = 0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (150) @(negedge clk);
    check("midr_tx_low", tx, 1'b0);
    rst = 1'b1;
    mon_abort = 1'b1;
    @(negedge clk);
    check("midr_tx_high", tx, 1'b1);
    repeat (2) @(negedge clk);
    tx_q.delete();
    release_reset();
    wait_frames(2, 2400, "midr_restart");
    if (tx_q.size() >= 2) begin
      check("midr_first", tx_q[0].b, 8'h41);
      check("midr_second", tx_q[1].b, 8'h52);
      check_range("midr_lat", int'(tx_q[0].t0 - rel_cyc), 0, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_banner_echo_top.md
Name: uart_banner_echo_top

Overview:
- FPGA top-level for the 12 MHz board. Holds a UART transmitter, a UART receiver, a fixed boot-banner sequencer and an LED register.
- After reset release it transmits the banner "ARM\r\n" once.
- After the banner it echoes every correctly framed received byte back on TX.
- LEDs show the last correctly received byte.

Parameters:
- CLK_FREQ_HZ, 12000000, board clock frequency.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (integer division, 104), clock cycles per UART bit.

Ports:
- CLK_I  input  1  system clock, 12 MHz, rising edge.
- UART_RTS_N_I  input  1  reset. Synchronous and active-high: 1 = in reset. The port name is inherited from the board pin.
- UART_RX_I  input  1  UART receive line, asynchronous, idle high.
- UART_TX_O  output  1  UART transmit line, idle high.
- LED_IO  output  8  LED drive, 1 = LED on.

Behaviour:
- Reset (UART_RTS_N_I=1 sampled on a rising edge):
  - UART_TX_O=1, LED_IO=8'h00.
  - Banner index=0, RX state=IDLE, echo buffer empty, all counters 0.
  - Reset mid-frame aborts the frame. TX returns high on the next edge.
- Frame format: 8N1, LSB first. Each bit, including the start and stop bits, lasts exactly CLKS_PER_BIT cycles.
- TX engine:
  - States: IDLE, START, DATA(0..7), STOP.
  - Accepts a byte only in IDLE.
  - UART_TX_O is registered. The start bit appears on the edge after acceptance.
  - A new byte can be accepted on the cycle after STOP completes, so back-to-back frames have no extra idle bits.
- Banner sequencer:
  - On the first cycle after reset deasserts, it issues 0x41, 0x52, 0x4D, 0x0D, 0x0A in order, each as soon as TX is IDLE.
  - The start bit of 'A' begins at most 2 cycles after reset release.
  - The full banner takes 5*10*CLKS_PER_BIT cycles (5200), plus at most 2 cycles per byte.
  - After the last byte the sequencer enters DONE and never re-sends until the next reset.
- RX engine:
  - UART_RX_I passes through a 2-flop synchronizer.
  - IDLE: a synchronized falling edge (1 to 0) starts a frame.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If the line is 1, it is a glitch: return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 times, shifting LSB first.
  - STOP: sample once more after CLKS_PER_BIT cycles.
    - Stop=1: byte valid for one cycle.
    - Stop=0: framing error. Discard the byte, do not update LEDs, wait for the line to be high, then return to IDLE.
  - With UART_RX_I held at 1, RX never leaves IDLE.
- LEDs: LED_IO is loaded with each valid received byte on the cycle after the valid pulse. It is otherwise held.
- Echo buffer (1 entry):
  - A valid RX byte is written into the buffer and marked full.
  - When the buffer is full, the banner is DONE and TX is IDLE, the buffer byte is sent and the buffer empties.
  - A byte arriving while the buffer is full overwrites the older byte, which is dropped.
  - Bytes received during the banner are held and sent after 0x0A.
- Simultaneous events: an RX valid pulse on the same cycle the buffer drains keeps the new byte in the buffer (full).

Test Plan:
- Hold UART_RX_I=1, reset for 100 ns, then release; run 800 µs.
  - Required TX output: 'A','R','M',CR,LF (0x41,0x52,0x4D,0x0D,0x0A), each bit 104 cycles, LSB first.
  - UART_TX_O=1 afterwards.
  - LED_IO=8'h00 throughout.
- After the banner, drive 0x5A at 115200 baud on UART_RX_I.
  - LED_IO=8'h5A within 2 cycles of the stop-bit sample.
  - TX echoes 0x5A, starting within 3 cycles of the stop-bit sample.
- Drive 0x33 while the banner is in progress.
  - LED_IO=8'h33 immediately.
  - 0x33 is transmitted directly after 0x0A with no gap.
- Drive 0xC3 with the stop bit forced to 0.
  - LED_IO unchanged, no echo.
  - A following valid 0x11 is received and echoed normally.
- Drive a 20-cycle low glitch on UART_RX_I.
  - No byte received, LED_IO unchanged.
- Assert reset in the middle of the 'R' frame.
  - UART_TX_O=1 one cycle later.
  - After release, the banner restarts from 'A'.
